// File: rtl/psum_wb_collector.sv
// Partial-sum writeback collector: accumulates PE partial sums, requantizes and writes ofmap words.
// Optional build macro PSUM_WB_RELU_EN clamps negative results to zero before saturation.
module psum_wb_collector #(
  parameter int ADDR_W = 8,
  parameter int QSHIFT = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               layer,
  input  logic                     start,
  input  logic [7:0]               pass_num,
  input  logic [ADDR_W-1:0]        out_num,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     wb_en,
  input  logic signed [18:0]       groupsum_in1,
  input  logic signed [18:0]       groupsum_in2,
  output logic                     ofmap_we,
  output logic [ADDR_W-1:0]        ofmap_addr,
  output logic [15:0]              ofmap_wdata,
  output logic [1:0]               ofmap_be,
  output logic                     busy,
  output logic                     done
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_RUN   | accepting partial sums
  // S_DRAIN | last result in the requant/write pipeline
  // S_DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic signed [27:0] RND = 28'sd1 <<< (QSHIFT - 1);

  state_t state, state_nxt;

  logic                     accept;
  logic                     last_pass;
  logic                     last_out;
  logic                     dual;
  logic [7:0]               pass_rel;
  logic [7:0]               pass_left;
  logic [ADDR_W-1:0]        outs_left;
  logic [ADDR_W-1:0]        cur_addr;
  logic signed [26:0]       acc0, acc1;
  logic signed [26:0]       sum0, sum1;
  logic signed [26:0]       res0, res1;
  logic                     res_vld;
  logic                     res_dual;
  logic [ADDR_W-1:0]        res_addr;

  function automatic logic [7:0] requant(input logic signed [26:0] r);
    logic signed [27:0] t;
    t = {r[26], r} + RND;
    t = t >>> QSHIFT;
`ifdef PSUM_WB_RELU_EN
    if (t < 28'sd0) t = 28'sd0;
`endif
    if (t > 28'sd127)
      return 8'h7f;
    else if (t < -28'sd128)
      return 8'h80;
    else
      return t[7:0];
  endfunction

  assign last_pass = (pass_left == 8'd0);
  assign last_out  = (outs_left == '0);
  assign sum0      = acc0 + 27'(groupsum_in1);
  assign sum1      = dual ? (acc1 + 27'(groupsum_in2)) : 27'sd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && last_pass && last_out) state_nxt = S_DRAIN;
      // res_vld low means the write now on the bus is the job's last one
      S_DRAIN: if (ofmap_we && !res_vld) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept = (state == S_RUN) && wb_en;
    busy   = (state == S_RUN) || (state == S_DRAIN);
    done   = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dual      <= 1'b0;
      pass_rel  <= 8'd0;
      pass_left <= 8'd0;
      outs_left <= '0;
      cur_addr  <= '0;
      acc0      <= '0;
      acc1      <= '0;
      res0      <= '0;
      res1      <= '0;
      res_vld   <= 1'b0;
      res_dual  <= 1'b0;
      res_addr  <= '0;
    end else begin
      res_vld <= 1'b0;
      if (state == S_IDLE && start) begin
        dual      <= (layer == 4'd5);
        pass_rel  <= (pass_num == 8'd0) ? 8'd0 : pass_num - 8'd1;
        pass_left <= (pass_num == 8'd0) ? 8'd0 : pass_num - 8'd1;
        outs_left <= (out_num == '0) ? '0 : out_num - ADDR_W'(1);
        cur_addr  <= base_addr;
        acc0      <= '0;
        acc1      <= '0;
      end else if (accept) begin
        if (last_pass) begin
          res0      <= sum0;
          res1      <= sum1;
          res_vld   <= 1'b1;
          res_dual  <= dual;
          res_addr  <= cur_addr;
          acc0      <= '0;
          acc1      <= '0;
          pass_left <= pass_rel;
          cur_addr  <= cur_addr + ADDR_W'(1);
          outs_left <= outs_left - ADDR_W'(1);
        end else begin
          acc0      <= sum0;
          acc1      <= sum1;
          pass_left <= pass_left - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ofmap_we    <= 1'b0;
      ofmap_addr  <= '0;
      ofmap_wdata <= 16'h0000;
      ofmap_be    <= 2'b00;
    end else begin
      ofmap_we <= res_vld;
      if (res_vld) begin
        ofmap_addr  <= res_addr;
        ofmap_wdata <= {res_dual ? requant(res1) : 8'h00, requant(res0)};
        ofmap_be    <= res_dual ? 2'b11 : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_psum_wb_collector.sv
// Randomized bench for psum_wb_collector against a sum-and-round reference model.
module tb_psum_wb_collector;
  localparam int QS = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  layer;
  logic        start;
  logic [7:0]  pass_num;
  logic [7:0]  out_num;
  logic [7:0]  base_addr;
  logic        wb_en;
  logic signed [18:0] gs1, gs2;
  logic        ofmap_we;
  logic [7:0]  ofmap_addr;
  logic [15:0] ofmap_wdata;
  logic [1:0]  ofmap_be;
  logic        busy;
  logic        done;

  psum_wb_collector #(.ADDR_W(8), .QSHIFT(QS)) dut (
    .clk(clk), .rst(rst), .layer(layer), .start(start), .pass_num(pass_num),
    .out_num(out_num), .base_addr(base_addr), .wb_en(wb_en),
    .groupsum_in1(gs1), .groupsum_in2(gs2), .ofmap_we(ofmap_we),
    .ofmap_addr(ofmap_addr), .ofmap_wdata(ofmap_wdata), .ofmap_be(ofmap_be),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_t;

  wr_t expq[$];
  int  dir1[$];
  int  dir2[$];
  int  exp_done = -1;
  bit  we_seen, done_seen;
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Round-half-up of s / 2^QS via floor division, then clamp.
  function automatic logic [7:0] quant(input longint s);
    longint d, x, q;
    logic [7:0] b;
    d = longint'(1) << QS;
    x = s + d / 2;
    if (x >= 0) q = x / d;
    else        q = -((-x + d - 1) / d);
`ifdef PSUM_WB_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    b = q[7:0];
    return b;
  endfunction

  function automatic int rnd19();
    if ($urandom_range(0, 2) == 0)
      return int'($urandom_range(0, 524287)) - 262144;
    return int'($urandom_range(0, 40000)) - 20000;
  endfunction

  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (ofmap_we) begin
      we_seen = 1;
      if (expq.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        e = expq.pop_front();
        check("we_cycle", cyc, e.cyc);
        check("addr", ofmap_addr, e.addr);
        check("wdata", ofmap_wdata, e.data);
        check("be", ofmap_be, e.be);
      end
    end
    if (done) begin
      done_seen = 1;
      check("done_cycle", cyc, exp_done);
      check("busy_at_done", busy, 0);
    end
  endtask

  task automatic run_job(input logic [3:0] lay, input int pn, input int on,
                         input logic [7:0] base, input bit hold, input bit poke);
    int pe, oe, total, n, it;
    bit dm, en;
    longint s0, s1;
    int v1, v2;
    wr_t w;
    pe = (pn == 0) ? 1 : pn;
    oe = (on == 0) ? 1 : on;
    dm = (lay == 4'd5);
    total = pe * oe;
    if (poke) begin
      wb_en = 1; gs1 = 19'sd90000; gs2 = 19'sd90000;
      tick();
      wb_en = 0;
    end
    layer = lay; pass_num = 8'(pn); out_num = 8'(on); base_addr = base;
    start = 1;
    tick();
    start = 0;
    check("busy_after_start", busy, 1);
    n = 0; it = 0; s0 = 0; s1 = 0;
    while (n < total) begin
      en = hold || ($urandom_range(0, 2) != 0);
      if (poke && it == 1) begin
        start = 1; layer = dm ? 4'd0 : 4'd5; pass_num = 8'd1; out_num = 8'd1;
        base_addr = base + 8'h40;
      end
      wb_en = en;
      v1 = rnd19(); v2 = rnd19();
      if (dir1.size() != 0 && en) begin
        v1 = dir1.pop_front();
        v2 = dir2.pop_front();
      end
      gs1 = 19'(v1); gs2 = 19'(v2);
      if (en) begin
        s0 += v1;
        if (dm) s1 += v2;
        n++;
        if (n % pe == 0) begin
          w.cyc  = cyc + 2;
          w.addr = base + 8'(n / pe - 1);
          w.data = {dm ? quant(s1) : 8'h00, quant(s0)};
          w.be   = dm ? 2'b11 : 2'b01;
          expq.push_back(w);
          s0 = 0; s1 = 0;
          if (n == total) exp_done = cyc + 3;
        end
      end
      tick();
      start = 0;
      it++;
    end
    wb_en = 0;
    done_seen = 0;
    for (int i = 0; i < 12 && !done_seen; i++) tick();
    check("done_seen", done_seen, 1);
    check("writes_left", expq.size(), 0);
    expq.delete();
    tick();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    rst = 1; layer = 0; start = 0; pass_num = 0; out_num = 0; base_addr = 0;
    wb_en = 0; gs1 = 0; gs2 = 0;
    tick(); tick();
    rst = 0;
    tick();
    check("rst_we", ofmap_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", ofmap_addr, 0);
    check("rst_wdata", ofmap_wdata, 0);
    check("rst_be", ofmap_be, 0);

    dir1 = '{100, 200, 300}; dir2 = '{7000, 7000, 7000};
    run_job(4'd0, 3, 1, 8'h10, 1'b0, 1'b0);
    dir1 = '{-1000}; dir2 = '{20000};
    run_job(4'd5, 1, 1, 8'h20, 1'b1, 1'b0);
    run_job(4'd0, 2, 4, 8'h30, 1'b1, 1'b0);
    run_job(4'd5, 2, 4, 8'h31, 1'b1, 1'b0);
    run_job(4'd0, 1, 3, 8'hFE, 1'b0, 1'b0);
    run_job(4'd5, 3, 2, 8'h50, 1'b0, 1'b1);
    run_job(4'd0, 0, 0, 8'h60, 1'b1, 1'b0);

    // reset one cycle after the final partial sum drops the write
    layer = 4'd0; pass_num = 8'd2; out_num = 8'd1; base_addr = 8'h70;
    start = 1; tick(); start = 0;
    wb_en = 1; gs1 = 19'sd1000; tick(); tick();
    wb_en = 0;
    rst = 1;
    expq.delete();
    exp_done = -1;
    we_seen = 0; done_seen = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 6; i++) tick();
    check("rst_mid_we", we_seen, 0);
    check("rst_mid_done", done_seen, 0);
    check("rst_mid_busy", busy, 0);
    run_job(4'd5, 2, 2, 8'h80, 1'b0, 1'b0);

    for (int j = 0; j < 12; j++)
      run_job(($urandom_range(0, 1) != 0) ? 4'd5 : 4'(j % 5), $urandom_range(0, 6),
              $urandom_range(0, 5), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 1) != 0), (j % 4 == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
